// File: rtl/secded_pkg.sv
// Shared types and bit-layout constants for the SEC-DED (16,11) decode engine.
package secded_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_LO,
        RD_HI,
        CAP,
        DEC,
        WR_LO,
        WR_HI,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        CLEAN,
        SINGLE,
        DOUBLE
    } err_class_t;

    localparam int NUM_DATA = 11;
    localparam int P0_POS   = 0;

    // d1..d11 occupy every non-power-of-two index of the codeword
    localparam int DATA_POS [NUM_DATA] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};

    function automatic logic [NUM_DATA-1:0] extract_data(input logic [15:0] code);
        logic [NUM_DATA-1:0] d;
        d = '0;
        for (int k = 0; k < NUM_DATA; k++) begin
            d[k] = code[DATA_POS[k]];
        end
        return d;
    endfunction

endpackage

// File: rtl/secded16_decode.sv
// Combinational SEC-DED (16,11) decoder: syndrome, overall parity, correction.
module secded16_decode
    import secded_pkg::*;
(
    input  logic [15:0] code,
    output logic [10:0] data,
    output err_class_t  err_class
);

    logic [3:0]  syn;
    logic        par;
    logic [15:0] fixed;

    always_comb begin
        syn = '0;
        for (int i = 1; i < 16; i++) begin
            if (code[i]) begin
                syn = syn ^ 4'(i);
            end
        end
        par       = ^code;
        fixed     = code;
        err_class = CLEAN;
        if (par) begin
            // a zero syndrome with odd parity means p0 itself flipped
            err_class = SINGLE;
            if (syn == 4'd0) begin
                fixed[P0_POS] = ~code[P0_POS];
            end else begin
                fixed = code ^ (16'd1 << syn);
            end
        end else if (syn != 4'd0) begin
            err_class = DOUBLE;
        end
        data = extract_data(fixed);
    end

endmodule

// File: rtl/secded_mem_engine.sv
// Memory-mapped SEC-DED decode engine: reads encoded words over a byte port,
// corrects them and writes the 11-bit messages plus a double-error flag back.
module secded_mem_engine
    import secded_pkg::*;
#(
    parameter int AW        = 8,
    parameter int SRC_BASE  = 64,
    parameter int DST_BASE  = 94,
    parameter int NUM_WORDS = 15,
    parameter int CW        = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req,
    output logic          ack,
    output logic [AW-1:0] mem_addr,
    output logic          mem_wr_en,
    output logic [7:0]    mem_wr_data,
    input  logic [7:0]    mem_rd_data,
    output logic          busy,
    output logic [CW-1:0] n_single,
    output logic [CW-1:0] n_double
);

    localparam logic [AW-1:0] SRC = AW'(SRC_BASE);
    localparam logic [AW-1:0] DST = AW'(DST_BASE);
    localparam logic [6:0]    LAST_IDX = 7'(NUM_WORDS - 1);

    state_t      state;
    state_t      state_nxt;
    logic [6:0]  idx;
    logic [7:0]  lo_byte;
    logic [7:0]  hi_byte;
    logic [15:0] result;
    logic [10:0] dec_data;
    err_class_t  dec_class;
    logic        last;
    logic [AW-1:0] src_addr;
    logic [AW-1:0] dst_addr;

    assign last     = (idx == LAST_IDX);
    assign src_addr = SRC + AW'({idx, 1'b0});
    assign dst_addr = DST + AW'({idx, 1'b0});

    secded16_decode u_dec (
        .code      ({hi_byte, lo_byte}),
        .data      (dec_data),
        .err_class (dec_class)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = req ? RD_LO : IDLE;
            RD_LO:   state_nxt = RD_HI;
            RD_HI:   state_nxt = CAP;
            CAP:     state_nxt = DEC;
            DEC:     state_nxt = WR_LO;
            WR_LO:   state_nxt = WR_HI;
            WR_HI:   state_nxt = last ? DONE : RD_LO;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mem_addr    = '0;
        mem_wr_en   = 1'b0;
        mem_wr_data = '0;
        case (state)
            RD_LO: mem_addr = src_addr;
            RD_HI: mem_addr = src_addr + AW'(1);
            WR_LO: begin
                mem_addr    = dst_addr;
                mem_wr_en   = 1'b1;
                mem_wr_data = result[7:0];
            end
            WR_HI: begin
                mem_addr    = dst_addr + AW'(1);
                mem_wr_en   = 1'b1;
                mem_wr_data = result[15:8];
            end
            default: ;
        endcase
    end

    // read data lags the address by one cycle, hence the RD_HI/CAP captures
    always_ff @(posedge clk) begin
        if (reset) begin
            idx      <= '0;
            lo_byte  <= '0;
            hi_byte  <= '0;
            result   <= '0;
            n_single <= '0;
            n_double <= '0;
            ack      <= 1'b0;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        idx      <= '0;
                        n_single <= '0;
                        n_double <= '0;
                        ack      <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                RD_HI: lo_byte <= mem_rd_data;
                CAP:   hi_byte <= mem_rd_data;
                DEC: begin
                    if (dec_class == DOUBLE) begin
                        result <= {1'b1, 4'b0, dec_data};
                    end else begin
                        result <= {5'b0, dec_data};
                    end
                    if (dec_class == SINGLE && n_single != '1) begin
                        n_single <= n_single + 1'b1;
                    end
                    if (dec_class == DOUBLE && n_double != '1) begin
                        n_double <= n_double + 1'b1;
                    end
                end
                WR_HI: begin
                    if (!last) begin
                        idx <= idx + 7'd1;
                    end
                end
                DONE: begin
                    ack  <= 1'b1;
                    busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_secded_mem_engine.sv
// Bench for secded_mem_engine: byte memory model, directed table and random runs.
module tb_secded_mem_engine;

    localparam int NW  = 15;
    localparam int SRC = 64;
    localparam int DST = 94;
    localparam int LAT = 6 * NW + 1;

    logic       clk = 1'b0;
    logic       reset;
    logic       req;
    logic       ack;
    logic [7:0] mem_addr;
    logic       mem_wr_en;
    logic [7:0] mem_wr_data;
    logic [7:0] mem_rd_data;
    logic       busy;
    logic [7:0] n_single;
    logic [7:0] n_double;

    logic [7:0] mem [256];
    int         wr_cnt = 0;
    int         n_cmp  = 0;
    int         n_bad  = 0;

    always #5 clk = ~clk;

    secded_mem_engine dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .ack         (ack),
        .mem_addr    (mem_addr),
        .mem_wr_en   (mem_wr_en),
        .mem_wr_data (mem_wr_data),
        .mem_rd_data (mem_rd_data),
        .busy        (busy),
        .n_single    (n_single),
        .n_double    (n_double)
    );

    always @(posedge clk) begin
        mem_rd_data <= mem[mem_addr];
        if (mem_wr_en) begin
            mem[mem_addr] <= mem_wr_data;
            wr_cnt <= wr_cnt + 1;
        end
    end

    typedef struct {
        logic [10:0] msg;
        logic [15:0] mask;
        logic [15:0] exp;
    } vec_t;

    vec_t tbl [NW];

    // Hamming placement: data fills non-power-of-two indices, p_k covers
    // indices with bit k set, p0 makes the whole word even parity.
    function automatic logic [15:0] encode(input logic [10:0] m);
        logic [15:0] c;
        int k;
        logic x;
        c = '0;
        k = 0;
        for (int b = 1; b < 16; b++) begin
            if ((b & (b - 1)) != 0) begin
                c[b] = m[k];
                k++;
            end
        end
        for (int p = 0; p < 4; p++) begin
            x = 1'b0;
            for (int b = 1; b < 16; b++) begin
                if ((b & (1 << p)) != 0) x = x ^ c[b];
            end
            c[1 << p] = x;
        end
        c[0] = ^c;
        return c;
    endfunction

    function automatic logic [10:0] raw_data(input logic [15:0] c);
        logic [10:0] m;
        int k;
        m = '0;
        k = 0;
        for (int b = 1; b < 16; b++) begin
            if ((b & (b - 1)) != 0) begin
                m[k] = c[b];
                k++;
            end
        end
        return m;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic load(input int i, input logic [15:0] code);
        mem[SRC + 2 * i]     = code[7:0];
        mem[SRC + 2 * i + 1] = code[15:8];
    endtask

    task automatic clear_dst();
        for (int a = DST; a < DST + 2 * NW; a++) mem[a] = 8'hEE;
    endtask

    function automatic logic [15:0] out_word(input int i);
        return {mem[DST + 2 * i + 1], mem[DST + 2 * i]};
    endfunction

    task automatic do_run(input int pulse_at, output int lat);
        int cyc;
        @(negedge clk);
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        chk("busy_after_accept", busy, 1);
        chk("ack_after_accept", ack, 0);
        cyc = 0;
        while (!ack && cyc < 200) begin
            @(negedge clk);
            cyc++;
            req = (cyc == pulse_at);
        end
        req = 1'b0;
        lat = cyc;
        chk("busy_at_ack", busy, 0);
    endtask

    initial begin
        int lat;
        int w0;
        int exp_s;
        int exp_d;
        int snap;
        logic any_ack;
        logic [10:0] m;
        logic [15:0] mask;
        logic [15:0] code;
        logic [15:0] exp_w [NW];
        int kind;
        int p1;
        int p2;

        tbl[0]  = '{11'h000, 16'h0000, 16'h0000};
        tbl[1]  = '{11'h5A3, 16'h0200, 16'h05A3};
        tbl[2]  = '{11'h5A3, 16'h0001, 16'h05A3};
        tbl[3]  = '{11'h5A3, 16'h1008, 16'h8522};
        tbl[4]  = '{11'h7FF, 16'h0000, 16'h07FF};
        tbl[5]  = '{11'h7FF, 16'h8000, 16'h07FF};
        tbl[6]  = '{11'h123, 16'h0002, 16'h0123};
        tbl[7]  = '{11'h123, 16'h0100, 16'h0123};
        tbl[8]  = '{11'h000, 16'h0006, 16'h8000};
        tbl[9]  = '{11'h7FF, 16'h0021, 16'h87FD};
        tbl[10] = '{11'h2AA, 16'h0000, 16'h02AA};
        tbl[11] = '{11'h555, 16'h0008, 16'h0555};
        tbl[12] = '{11'h555, 16'hC000, 16'h8355};
        tbl[13] = '{11'h001, 16'h0080, 16'h0001};
        tbl[14] = '{11'h400, 16'h0000, 16'h0400};

        for (int a = 0; a < 256; a++) mem[a] = 8'h00;
        reset = 1'b1;
        req   = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ack", ack, 0);
        chk("rst_busy", busy, 0);
        chk("rst_wr_en", mem_wr_en, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wr_data", mem_wr_data, 0);
        chk("rst_n_single", n_single, 0);
        chk("rst_n_double", n_double, 0);
        reset = 1'b0;
        @(negedge clk);

        // directed table
        for (int i = 0; i < NW; i++) load(i, encode(tbl[i].msg) ^ tbl[i].mask);
        clear_dst();
        w0 = wr_cnt;
        do_run(0, lat);
        chk("tbl_latency", lat, LAT);
        for (int i = 0; i < NW; i++) chk($sformatf("tbl_word%0d", i), out_word(i), tbl[i].exp);
        chk("tbl_n_single", n_single, 7);
        chk("tbl_n_double", n_double, 4);
        chk("tbl_writes", wr_cnt - w0, 2 * NW);
        repeat (3) @(negedge clk);
        chk("ack_held", ack, 1);
        chk("cnt_held", n_single, 7);

        // randomized runs; the last one also pulses req mid-run
        for (int r = 0; r < 4; r++) begin
            exp_s = 0;
            exp_d = 0;
            for (int i = 0; i < NW; i++) begin
                m    = 11'($urandom);
                kind = $urandom_range(0, 2);
                p1   = $urandom_range(0, 15);
                p2   = (p1 + $urandom_range(1, 15)) % 16;
                mask = '0;
                if (kind >= 1) mask[p1] = 1'b1;
                if (kind == 2) mask[p2] = 1'b1;
                code = encode(m) ^ mask;
                load(i, code);
                if (kind == 2) begin
                    exp_w[i] = {1'b1, 4'b0, raw_data(code)};
                    exp_d++;
                end else begin
                    exp_w[i] = {5'b0, m};
                    if (kind == 1) exp_s++;
                end
            end
            clear_dst();
            w0 = wr_cnt;
            do_run((r == 3) ? 30 : 0, lat);
            chk($sformatf("rnd%0d_latency", r), lat, LAT);
            for (int i = 0; i < NW; i++) begin
                chk($sformatf("rnd%0d_word%0d", r, i), out_word(i), exp_w[i]);
            end
            chk($sformatf("rnd%0d_n_single", r), n_single, exp_s);
            chk($sformatf("rnd%0d_n_double", r), n_double, exp_d);
            chk($sformatf("rnd%0d_writes", r), wr_cnt - w0, 2 * NW);
        end

        // reset 20 cycles into a run
        for (int i = 0; i < NW; i++) load(i, 16'h0000);
        clear_dst();
        @(negedge clk);
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        repeat (19) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        snap = wr_cnt;
        any_ack = 1'b0;
        repeat (120) begin
            @(negedge clk);
            any_ack = any_ack | ack;
        end
        chk("rst_mid_ack", any_ack, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_no_writes", wr_cnt - snap, 0);

        clear_dst();
        w0 = wr_cnt;
        do_run(0, lat);
        chk("post_rst_latency", lat, LAT);
        for (int i = 0; i < NW; i++) chk($sformatf("post_rst_word%0d", i), out_word(i), 0);
        chk("post_rst_n_single", n_single, 0);
        chk("post_rst_n_double", n_double, 0);
        chk("post_rst_writes", wr_cnt - w0, 2 * NW);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
